// File: rtl/pulse_evt_pkg.sv
// Shared types for the pulse event collector: output record layout and
// output-stage state encoding.
package pulse_evt_pkg;

  localparam int unsigned CH_W_MAX  = 5;
  localparam int unsigned CNT_W_MAX = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Fields are sized for the widest configuration; users slice what they need.
  typedef struct packed {
    logic [CH_W_MAX-1:0]  channel;
    logic [CNT_W_MAX-1:0] count;
    logic                 ovf;
  } evt_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester after the last
// granted index, with the last grant remembered across enabled cycles.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int unsigned W = $clog2(N);

  logic [W-1:0] r_last;
  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_pick;
  logic [W-1:0] w_idx;

  // Prefer requesters above the last grant, else wrap to the lowest index.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_mask[i] = (i > 32'(r_last));
    end
    w_hi   = req & w_mask;
    w_pick = (|w_hi) ? (w_hi & (~w_hi + N'(1))) : (req & (~req + N'(1)));
    grant  = en ? w_pick : '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_idx = W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_last <= W'(N - 1);
    end else if (|grant) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/pulse_event_collector.sv
// Collects per-channel event pulses into saturating counters and hands one
// coalesced record at a time to a valid/ready consumer, round-robin.
module pulse_event_collector
  import pulse_evt_pkg::*;
#(
  parameter  int unsigned NB_CHANNEL = 4,
  parameter  int unsigned CNT_W      = 8,
  localparam int unsigned CH_W       = $clog2(NB_CHANNEL)
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic [NB_CHANNEL-1:0] pulse_i,
  output logic [NB_CHANNEL-1:0] pending_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic [CH_W-1:0]       tchannel_o,
  output logic [CNT_W-1:0]      tcount_o,
  output logic                  tovf_o
);

  logic [NB_CHANNEL-1:0] r_pending;
  logic [CNT_W-1:0]      r_cnt [NB_CHANNEL];
  logic [NB_CHANNEL-1:0] r_ovf;
  out_state_e            r_state;
  evt_rec_t              r_out;

  logic                  w_hs;
  logic                  w_can_load;
  logic                  w_load;
  logic [NB_CHANNEL-1:0] w_grant;
  evt_rec_t              w_rec;
  logic                  w_unused_rec;

  assign w_hs       = (r_state == FULL) && tready_i;
  assign w_can_load = (r_state == EMPTY) || w_hs;

  rr_arbiter #(
    .N (NB_CHANNEL)
  ) u_arb (
    .clk   (aclk),
    .srst  (srst),
    .req   (r_pending),
    .en    (w_can_load),
    .grant (w_grant)
  );

  assign w_load = |w_grant;

  // Mux the granted channel's counter state into a record.
  always_comb begin
    w_rec = '0;
    for (int unsigned ch = 0; ch < NB_CHANNEL; ch++) begin
      if (w_grant[ch]) begin
        w_rec.channel = CH_W_MAX'(ch);
        w_rec.count   = CNT_W_MAX'(r_cnt[ch]);
        w_rec.ovf     = r_ovf[ch];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_pending <= '0;
      r_ovf     <= '0;
      for (int unsigned ch = 0; ch < NB_CHANNEL; ch++) begin
        r_cnt[ch] <= '0;
      end
      r_state <= EMPTY;
      r_out   <= '0;
    end else begin
      // A granted channel restarts from the pulse arriving in the same cycle.
      for (int unsigned ch = 0; ch < NB_CHANNEL; ch++) begin
        if (w_grant[ch]) begin
          r_pending[ch] <= pulse_i[ch];
          r_cnt[ch]     <= pulse_i[ch] ? CNT_W'(1) : '0;
          r_ovf[ch]     <= 1'b0;
        end else if (pulse_i[ch]) begin
          r_pending[ch] <= 1'b1;
          if (r_cnt[ch] == '1) begin
            r_ovf[ch] <= 1'b1;
          end else begin
            r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
          end
        end
      end

      if (w_load) begin
        r_state <= FULL;
        r_out   <= w_rec;
      end else if (w_hs) begin
        r_state <= EMPTY;
      end
    end
  end

  assign pending_o    = r_pending;
  assign tvalid_o     = (r_state == FULL);
  assign tchannel_o   = r_out.channel[CH_W-1:0];
  assign tcount_o     = r_out.count[CNT_W-1:0];
  assign tovf_o       = r_out.ovf;
  assign w_unused_rec = ^r_out;

endmodule

// File: tb/tb_pulse_event_collector.sv
// Directed bench for pulse_event_collector: records are predicted into
// queues as stimulus is applied and checked on every output handshake.
module tb_pulse_event_collector;
  import pulse_evt_pkg::*;

  logic       aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Default configuration instance
  logic       srst;
  logic [3:0] pulse;
  logic       tready;
  logic [3:0] pending;
  logic       tvalid;
  logic [1:0] tchannel;
  logic [7:0] tcount;
  logic       tovf;

  // Narrow-counter instance for saturation
  logic       s_srst;
  logic [3:0] s_pulse;
  logic       s_tready;
  logic [3:0] s_pending;
  logic       s_tvalid;
  logic [1:0] s_tchannel;
  logic [1:0] s_tcount;
  logic       s_tovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  evt_rec_t    q_m[$];
  evt_rec_t    q_s[$];
  int unsigned rr_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  pulse_event_collector #(.NB_CHANNEL(4), .CNT_W(8)) dut (
    .aclk       (aclk),
    .srst       (srst),
    .pulse_i    (pulse),
    .pending_o  (pending),
    .tvalid_o   (tvalid),
    .tready_i   (tready),
    .tchannel_o (tchannel),
    .tcount_o   (tcount),
    .tovf_o     (tovf)
  );

  pulse_event_collector #(.NB_CHANNEL(4), .CNT_W(2)) dut_s (
    .aclk       (aclk),
    .srst       (s_srst),
    .pulse_i    (s_pulse),
    .pending_o  (s_pending),
    .tvalid_o   (s_tvalid),
    .tready_i   (s_tready),
    .tchannel_o (s_tchannel),
    .tcount_o   (s_tcount),
    .tovf_o     (s_tovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic evt_rec_t mk(input int unsigned ch, input int unsigned cnt, input logic ovf);
    evt_rec_t r;
    r         = '0;
    r.channel = CH_W_MAX'(ch);
    r.count   = CNT_W_MAX'(cnt);
    r.ovf     = ovf;
    return r;
  endfunction

  // Scoreboard: compare each accepted record against the predicted queue.
  always @(negedge aclk) begin
    evt_rec_t e;
    if (srst === 1'b0 && tvalid === 1'b1 && tready === 1'b1) begin
      chk("sb_m_expected", 32'(q_m.size() != 0), 1);
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("sb_m_channel", 32'(tchannel), 32'(e.channel));
        chk("sb_m_count", 32'(tcount), 32'(e.count));
        chk("sb_m_ovf", 32'(tovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge aclk) begin
    evt_rec_t e;
    if (s_srst === 1'b0 && s_tvalid === 1'b1 && s_tready === 1'b1) begin
      chk("sb_s_expected", 32'(q_s.size() != 0), 1);
      if (q_s.size() != 0) begin
        e = q_s.pop_front();
        chk("sb_s_channel", 32'(s_tchannel), 32'(e.channel));
        chk("sb_s_count", 32'(s_tcount), 32'(e.count));
        chk("sb_s_ovf", 32'(s_tovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    srst     = 1'b1;
    pulse    = 4'hF;
    tready   = 1'b1;
    s_srst   = 1'b1;
    s_pulse  = 4'h0;
    s_tready = 1'b0;

    // Reset with pulses applied: everything stays clear
    repeat (5) tick();
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tchannel", 32'(tchannel), 0);
    chk("rst_tcount", 32'(tcount), 0);
    chk("rst_tovf", 32'(tovf), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_s_tvalid", 32'(s_tvalid), 0);
    srst  = 1'b0;
    pulse = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_tvalid", 32'(tvalid), 0);
    end

    // Single event on ch2
    pulse = 4'b0100;
    tick();
    chk("single_pending", 32'(pending), 32'h4);
    chk("single_tvalid_early", 32'(tvalid), 0);
    pulse = 4'h0;
    q_m.push_back(mk(2, 1, 1'b0));
    tick();
    chk("single_tvalid", 32'(tvalid), 1);
    chk("single_tchannel", 32'(tchannel), 2);
    chk("single_tcount", 32'(tcount), 1);
    chk("single_pending_clr", 32'(pending), 0);
    tick();
    chk("single_tvalid_drop", 32'(tvalid), 0);

    // Coalescing under backpressure
    tready = 1'b0;
    pulse  = 4'b0001;
    tick();
    q_m.push_back(mk(0, 1, 1'b0));
    pulse = 4'h0;
    tick();
    chk("stall_tvalid", 32'(tvalid), 1);
    chk("stall_tchannel", 32'(tchannel), 0);
    pulse = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_ch", 32'(tchannel), 0);
      chk("stall_hold_cnt", 32'(tcount), 1);
    end
    pulse  = 4'h0;
    tready = 1'b1;
    q_m.push_back(mk(1, 3, 1'b0));
    tick();
    chk("coal_tchannel", 32'(tchannel), 1);
    chk("coal_tcount", 32'(tcount), 3);
    tready = 1'b0;
    pulse  = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("coal_hold_valid", 32'(tvalid), 1);
      chk("coal_hold_ch", 32'(tchannel), 1);
      chk("coal_hold_cnt", 32'(tcount), 3);
      chk("coal_pending", 32'(pending), 32'h2);
    end
    pulse  = 4'h0;
    tready = 1'b1;
    q_m.push_back(mk(1, 5, 1'b0));
    tick();
    chk("coal2_tcount", 32'(tcount), 5);
    tick();
    chk("coal_drain", 32'(tvalid), 0);

    // Round-robin from a fresh reset, all channels firing
    srst = 1'b1;
    tick();
    srst  = 1'b0;
    pulse = 4'hF;
    q_m.push_back(mk(0, 1, 1'b0));
    q_m.push_back(mk(1, 2, 1'b0));
    q_m.push_back(mk(2, 3, 1'b0));
    q_m.push_back(mk(3, 4, 1'b0));
    q_m.push_back(mk(0, 4, 1'b0));
    q_m.push_back(mk(1, 4, 1'b0));
    q_m.push_back(mk(2, 4, 1'b0));
    q_m.push_back(mk(3, 4, 1'b0));
    q_m.push_back(mk(0, 4, 1'b0));
    q_m.push_back(mk(1, 3, 1'b0));
    q_m.push_back(mk(2, 2, 1'b0));
    q_m.push_back(mk(3, 1, 1'b0));
    tick();
    chk("rr_first_pending", 32'(pending), 32'hF);
    chk("rr_first_tvalid", 32'(tvalid), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_tvalid", 32'(tvalid), 1);
      chk("rr_tchannel", 32'(tchannel), rr_seq[i]);
    end
    pulse = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_drain_tvalid", 32'(tvalid), 1);
      chk("rr_drain_tchannel", 32'(tchannel), rr_seq[i]);
    end
    tick();
    chk("rr_empty", 32'(tvalid), 0);

    // Saturation on the narrow-counter instance
    s_srst   = 1'b0;
    s_tready = 1'b0;
    s_pulse  = 4'b0010;
    tick();
    q_s.push_back(mk(1, 1, 1'b0));
    s_pulse = 4'h0;
    tick();
    chk("sat_block_valid", 32'(s_tvalid), 1);
    s_pulse = 4'b0001;
    repeat (6) tick();
    chk("sat_pending", 32'(s_pending), 32'h1);
    s_pulse  = 4'h0;
    s_tready = 1'b1;
    q_s.push_back(mk(0, 3, 1'b1));
    tick();
    chk("sat_tchannel", 32'(s_tchannel), 0);
    chk("sat_tcount", 32'(s_tcount), 3);
    chk("sat_tovf", 32'(s_tovf), 1);
    s_tready = 1'b0;
    s_pulse  = 4'b0001;
    tick();
    s_pulse = 4'h0;
    chk("sat_hold_ovf", 32'(s_tovf), 1);
    s_tready = 1'b1;
    q_s.push_back(mk(0, 1, 1'b0));
    tick();
    chk("sat_next_tcount", 32'(s_tcount), 1);
    chk("sat_next_tovf", 32'(s_tovf), 0);
    tick();
    chk("sat_empty", 32'(s_tvalid), 0);
    s_srst = 1'b1;

    // Pulse on ch3 in the same cycle it is loaded
    pulse = 4'b1000;
    tick();
    q_m.push_back(mk(3, 1, 1'b0));
    q_m.push_back(mk(3, 1, 1'b0));
    tick();
    pulse = 4'h0;
    chk("coll_tchannel", 32'(tchannel), 3);
    chk("coll_tcount", 32'(tcount), 1);
    chk("coll_pending", 32'(pending), 32'h8);
    tick();
    chk("coll_follow_valid", 32'(tvalid), 1);
    chk("coll_follow_ch", 32'(tchannel), 3);
    chk("coll_follow_cnt", 32'(tcount), 1);
    tick();
    chk("coll_empty", 32'(tvalid), 0);

    // Reset while a record is held
    tready = 1'b0;
    pulse  = 4'b0100;
    tick();
    pulse = 4'h0;
    tick();
    chk("mid_valid", 32'(tvalid), 1);
    pulse = 4'b0001;
    tick();
    srst = 1'b1;
    tick();
    chk("mid_rst_tvalid", 32'(tvalid), 0);
    chk("mid_rst_tchannel", 32'(tchannel), 0);
    chk("mid_rst_tcount", 32'(tcount), 0);
    chk("mid_rst_tovf", 32'(tovf), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    srst   = 1'b0;
    pulse  = 4'h0;
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", 32'(tvalid), 0);
      chk("mid_no_pending", 32'(pending), 0);
    end

    chk("sb_m_drained", 32'(q_m.size()), 0);
    chk("sb_s_drained", 32'(q_s.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
